speck_round_step: RTL and testbench

- One SPECK128/128 iteration, multi-cycle and start/finish handshaked.
- From a 128-bit key state and a 128-bit data block it produces two results together:
  - the next key state (key-schedule step using round_ctr);
  - the encrypted block (one ARX round keyed by the current round key).
- N instances chained (key_out→key_in, block_out→block_in, round_ctr=i) form the full cipher, sequenced by an external controller.

---
 rtl/speck_pkg.sv | 24 ++
 rtl/speck_arx.sv | 27 ++
 rtl/speck_round_step.sv | 131 +++++++++++++
 tb/tb_speck_round_step.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/speck_pkg.sv
// Shared widths, rotate amounts, FSM state codes and rotate helpers for the SPECK round step.
package speck_pkg;

    localparam int WORD_W = 64;
    localparam int ALPHA  = 8;
    localparam int BETA   = 3;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_ROT  = 4'd1,
        ST_ADD  = 4'd2,
        ST_MIX  = 4'd3,
        ST_DONE = 4'd4
    } state_e;

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] v, input int unsigned n);
        return (v >> n) | (v << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] v, input int unsigned n);
        return (v << n) | (v >> (WORD_W - n));
    endfunction

endpackage

// File: rtl/speck_arx.sv
// Combinational ARX word step: exposes the rotate, add and xor/rotate-mix pieces separately
// so the owning FSM can register each stage.
module speck_arx
    import speck_pkg::*;
(
    input  logic [WORD_W-1:0] i_rot_a,
    input  logic [WORD_W-1:0] i_rot_b,
    input  logic [WORD_W-1:0] i_add_a,
    input  logic [WORD_W-1:0] i_add_b,
    input  logic [WORD_W-1:0] i_sum,
    input  logic [WORD_W-1:0] i_mask,
    input  logic [WORD_W-1:0] i_rol,
    output logic [WORD_W-1:0] o_ror_a,
    output logic [WORD_W-1:0] o_rol_b,
    output logic [WORD_W-1:0] o_sum,
    output logic [WORD_W-1:0] o_mix_a,
    output logic [WORD_W-1:0] o_mix_b
);

    assign o_ror_a = ror(i_rot_a, ALPHA);
    assign o_rol_b = rol(i_rot_b, BETA);
    assign o_sum   = i_add_a + i_add_b;
    // The second output word depends on the freshly mixed first word.
    assign o_mix_a = i_sum ^ i_mask;
    assign o_mix_b = i_rol ^ o_mix_a;

endmodule

// File: rtl/speck_round_step.sv
// One SPECK128/128 round plus key-schedule step, sequenced IDLE->ROT->ADD->MIX->DONE.
// Optional macro SPECK_DECRYPT_EN adds a decrypt input selecting the inverse block round.
module speck_round_step
    import speck_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_start,
    input  logic [2*WORD_W-1:0]   key_in,
    input  logic [WORD_W-1:0]     round_ctr,
    input  logic [2*WORD_W-1:0]   block_in,
`ifdef SPECK_DECRYPT_EN
    input  logic                  decrypt,
`endif
    output logic [2*WORD_W-1:0]   key_out,
    output logic [2*WORD_W-1:0]   block_out,
    output logic                  finished,
    output logic [3:0]            state_response
);

    state_e              r_state;
    logic [WORD_W-1:0]   r_k, r_l, r_x, r_y, r_ctr;
    logic [WORD_W-1:0]   r_ror_l, r_rol_k, r_ror_x, r_rol_y;
    logic [WORD_W-1:0]   r_sum_l, r_sum_x;
    logic [2*WORD_W-1:0] r_key_out, r_block_out;
    logic                r_finished;

    logic [WORD_W-1:0]   w_ror_l, w_rol_k, w_sum_l, w_l_next, w_k_next;
    logic [WORD_W-1:0]   w_ror_x, w_rol_y, w_sum_x, w_x_next, w_y_next;
    logic [WORD_W-1:0]   w_stage_y, w_stage_sum_x;
    logic [2*WORD_W-1:0] w_block_next;

    // Key path: l is the rotated-right word, k the rotated-left word, round_ctr the mix mask.
    speck_arx u_key_arx (
        .i_rot_a (r_l),     .i_rot_b (r_k),
        .i_add_a (r_ror_l), .i_add_b (r_k),
        .i_sum   (r_sum_l), .i_mask  (r_ctr), .i_rol (r_rol_k),
        .o_ror_a (w_ror_l), .o_rol_b (w_rol_k), .o_sum (w_sum_l),
        .o_mix_a (w_l_next), .o_mix_b (w_k_next)
    );

    // Block path is keyed by the incoming k, not the scheduled k'.
    speck_arx u_block_arx (
        .i_rot_a (r_x),     .i_rot_b (r_y),
        .i_add_a (r_ror_x), .i_add_b (r_y),
        .i_sum   (r_sum_x), .i_mask  (r_k), .i_rol (r_rol_y),
        .o_ror_a (w_ror_x), .o_rol_b (w_rol_y), .o_sum (w_sum_x),
        .o_mix_a (w_x_next), .o_mix_b (w_y_next)
    );

`ifdef SPECK_DECRYPT_EN
    logic r_dec;

    // Inverse round reuses the same stage registers: r_rol_y holds y', r_sum_x holds (x^k)-y'.
    assign w_stage_y     = r_dec ? ror(r_y ^ r_x, BETA) : w_rol_y;
    assign w_stage_sum_x = r_dec ? ((r_x ^ r_k) - r_rol_y) : w_sum_x;
    assign w_block_next  = r_dec ? {rol(r_sum_x, ALPHA), r_rol_y} : {w_x_next, w_y_next};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_dec <= 1'b0;
        else if (r_state == ST_IDLE && signal_start)
            r_dec <= decrypt;
    end
`else
    assign w_stage_y     = w_rol_y;
    assign w_stage_sum_x = w_sum_x;
    assign w_block_next  = {w_x_next, w_y_next};
`endif

    // NOTE: all state here is non-blocking so every stage reads the previous cycle's values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_l         <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_ctr       <= '0;
            r_ror_l     <= '0;
            r_rol_k     <= '0;
            r_ror_x     <= '0;
            r_rol_y     <= '0;
            r_sum_l     <= '0;
            r_sum_x     <= '0;
            r_key_out   <= '0;
            r_block_out <= '0;
            r_finished  <= 1'b0;
        end else begin
            r_finished <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (signal_start) begin
                        r_k     <= key_in[2*WORD_W-1:WORD_W];
                        r_l     <= key_in[WORD_W-1:0];
                        r_x     <= block_in[2*WORD_W-1:WORD_W];
                        r_y     <= block_in[WORD_W-1:0];
                        r_ctr   <= round_ctr;
                        r_state <= ST_ROT;
                    end
                end
                ST_ROT: begin
                    r_ror_l <= w_ror_l;
                    r_rol_k <= w_rol_k;
                    r_ror_x <= w_ror_x;
                    r_rol_y <= w_stage_y;
                    r_state <= ST_ADD;
                end
                ST_ADD: begin
                    r_sum_l <= w_sum_l;
                    r_sum_x <= w_stage_sum_x;
                    r_state <= ST_MIX;
                end
                ST_MIX: begin
                    r_key_out   <= {w_k_next, w_l_next};
                    r_block_out <= w_block_next;
                    r_finished  <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign key_out        = r_key_out;
    assign block_out      = r_block_out;
    assign finished       = r_finished;
    assign state_response = r_state;

endmodule

// File: tb/tb_speck_round_step.sv
// Self-checking bench for speck_round_step against a word-level SPECK round model.
module tb_speck_round_step;

    logic         clk = 1'b0;
    logic         rst;
    logic         signal_start;
    logic         decrypt;
    logic [127:0] key_in, block_in;
    logic [63:0]  round_ctr;
    logic [127:0] key_out, block_out;
    logic         finished;
    logic [3:0]   state_response;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [127:0] STD_KEY = 128'h0706050403020100_0f0e0d0c0b0a0908;
    localparam logic [127:0] STD_PT  = 128'h6c61766975716520_7469206564616d20;
    localparam logic [127:0] STD_KO  = 128'h37253b31171d0309_0f1513110f0d0b09;
    localparam logic [127:0] STD_BO  = 128'h93d384dfced4df85_309a87f4eddfb686;
    localparam logic [127:0] STD_CT  = 128'ha65d985179783265_7860fedf5c570d18;

    speck_round_step dut (
        .clk            (clk),
        .rst            (rst),
        .signal_start   (signal_start),
        .key_in         (key_in),
        .round_ctr      (round_ctr),
        .block_in       (block_in),
`ifdef SPECK_DECRYPT_EN
        .decrypt        (decrypt),
`endif
        .key_out        (key_out),
        .block_out      (block_out),
        .finished       (finished),
        .state_response (state_response)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [63:0] rol64(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    // Reference round: returns {k', l', x', y'}.
    function automatic logic [255:0] model_step(input logic [127:0] key, input logic [63:0] ctr,
                                                input logic [127:0] blk, input logic dec);
        logic [63:0] k, l, x, y, k2, l2, x2, y2;
        k  = key[127:64];
        l  = key[63:0];
        x  = blk[127:64];
        y  = blk[63:0];
        l2 = (ror64(l, 8) + k) ^ ctr;
        k2 = rol64(k, 3) ^ l2;
        if (!dec) begin
            x2 = (ror64(x, 8) + y) ^ k;
            y2 = rol64(y, 3) ^ x2;
        end else begin
            y2 = ror64(x ^ y, 3);
            x2 = rol64((x ^ k) - y2, 8);
        end
        return {k2, l2, x2, y2};
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from IDLE; lat = edges from start sampling (inclusive) to finished, -1 on timeout.
    task automatic run_op(input logic [127:0] key, input logic [63:0] ctr, input logic [127:0] blk,
                          input logic dec, output logic [127:0] gk, output logic [127:0] gb,
                          output int lat, output logic fin_after);
        key_in       = key;
        round_ctr    = ctr;
        block_in     = blk;
        decrypt      = dec;
        signal_start = 1'b1;
        tick();
        signal_start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (finished === 1'b1) begin
                lat = c;
                break;
            end
            tick();
        end
        gk = key_out;
        gb = block_out;
        tick();
        fin_after = finished;
    endtask

    task automatic test_reset();
        rst = 1'b1; signal_start = 1'b0; decrypt = 1'b0;
        key_in = '0; block_in = '0; round_ctr = '0;
        tick(); tick();
        n_total++; if (state_response !== 4'd0) $display("FAIL reset_state: got %0d expected 0", state_response); else n_pass++;
        n_total++; if (finished !== 1'b0) $display("FAIL reset_finished: got %b expected 0", finished); else n_pass++;
        n_total++; if ({key_out, block_out} !== 256'd0) $display("FAIL reset_outputs: got %h %h expected 0", key_out, block_out); else n_pass++;
        @(negedge clk); rst = 1'b0;
        tick();
    endtask

    task automatic test_standard_vector();
        logic [127:0] gk, gb; int lat; logic fa;
        run_op(STD_KEY, 64'd0, STD_PT, 1'b0, gk, gb, lat, fa);
        n_total++; if (gk !== STD_KO) $display("FAIL std_key_out: got %h expected %h", gk, STD_KO); else n_pass++;
        n_total++; if (gb !== STD_BO) $display("FAIL std_block_out: got %h expected %h", gb, STD_BO); else n_pass++;
        n_total++; if (lat !== 4) $display("FAIL std_latency: got %0d expected 4", lat); else n_pass++;
        n_total++; if (fa !== 1'b0) $display("FAIL std_pulse_width: finished got %b expected 0", fa); else n_pass++;
        n_total++; if (key_out !== STD_KO || block_out !== STD_BO) $display("FAIL std_hold: got %h %h expected %h %h", key_out, block_out, STD_KO, STD_BO); else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        int fins = 0;
        key_in = STD_KEY; block_in = STD_PT; round_ctr = 64'd0;
        signal_start = 1'b1;
        tick();
        signal_start = 1'b0;
        n_total++; if (state_response !== 4'd1) $display("FAIL midrst_in_rot: got %0d expected 1", state_response); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (state_response !== 4'd0 || finished !== 1'b0) $display("FAIL midrst_state: got state %0d fin %b expected 0 0", state_response, finished); else n_pass++;
        n_total++; if ({key_out, block_out} !== 256'd0) $display("FAIL midrst_outputs: got %h %h expected 0", key_out, block_out); else n_pass++;
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (finished === 1'b1) fins++;
        end
        n_total++; if (fins !== 0) $display("FAIL midrst_no_pulse: got %0d finished pulses expected 0", fins); else n_pass++;
    endtask

    task automatic test_zero();
        logic [127:0] gk, gb; int lat; logic fa;
        run_op('0, 64'd0, '0, 1'b0, gk, gb, lat, fa);
        n_total++; if ({gk, gb} !== 256'd0) $display("FAIL zero_ctr0: got %h %h expected 0", gk, gb); else n_pass++;
        run_op('0, 64'd5, '0, 1'b0, gk, gb, lat, fa);
        n_total++; if (gk !== {64'd5, 64'd5}) $display("FAIL zero_ctr5_key: got %h expected %h", gk, {64'd5, 64'd5}); else n_pass++;
        n_total++; if (gb !== 128'd0) $display("FAIL zero_ctr5_block: got %h expected 0", gb); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        logic [127:0] ka, ba; logic [63:0] ca; logic [255:0] exp; int fins = 0;
        ka = {rand64(), rand64()}; ba = {rand64(), rand64()}; ca = rand64();
        exp = model_step(ka, ca, ba, 1'b0);
        key_in = ka; block_in = ba; round_ctr = ca; decrypt = 1'b0;
        signal_start = 1'b1;
        tick();
        signal_start = 1'b0;
        key_in = {rand64(), rand64()}; block_in = {rand64(), rand64()}; round_ctr = rand64();
        tick();
        n_total++; if (state_response !== 4'd2) $display("FAIL busy_in_add: got %0d expected 2", state_response); else n_pass++;
        signal_start = 1'b1;
        tick();
        signal_start = 1'b0;
        tick();
        n_total++; if (finished !== 1'b1) $display("FAIL busy_done: finished got %b expected 1", finished); else n_pass++;
        n_total++; if ({key_out, block_out} !== exp) $display("FAIL busy_first_capture: got %h %h expected %h", key_out, block_out, exp); else n_pass++;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (finished === 1'b1) fins++;
        end
        n_total++; if (fins !== 0) $display("FAIL busy_single_finish: got %0d extra pulses expected 0", fins); else n_pass++;
    endtask

    task automatic test_held_start();
        logic [255:0] exp; int fins = 0;
        key_in = {rand64(), rand64()}; block_in = {rand64(), rand64()}; round_ctr = rand64();
        decrypt = 1'b0;
        exp = model_step(key_in, round_ctr, block_in, 1'b0);
        signal_start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (finished === 1'b1) fins++;
        end
        signal_start = 1'b0;
        tick();
        n_total++; if (fins !== 2) $display("FAIL held_start_retrigger: got %0d finishes expected 2", fins); else n_pass++;
        n_total++; if ({key_out, block_out} !== exp) $display("FAIL held_start_result: got %h %h expected %h", key_out, block_out, exp); else n_pass++;
        tick(); tick(); tick();
    endtask

    task automatic test_random();
        logic [127:0] k, b, gk, gb; logic [63:0] c; logic d; logic [255:0] exp; int lat; logic fa;
        for (int i = 0; i < 16; i++) begin
            k = {rand64(), rand64()}; b = {rand64(), rand64()}; c = rand64();
`ifdef SPECK_DECRYPT_EN
            d = 1'($urandom_range(0, 1));
`else
            d = 1'b0;
`endif
            exp = model_step(k, c, b, d);
            run_op(k, c, b, d, gk, gb, lat, fa);
            n_total++; if ({gk, gb} !== exp) $display("FAIL random_%0d: got %h %h expected %h", i, gk, gb, exp); else n_pass++;
            n_total++; if (lat !== 4 || fa !== 1'b0) $display("FAIL random_timing_%0d: got lat %0d after %b expected 4 0", i, lat, fa); else n_pass++;
        end
    endtask

    task automatic test_chain();
        logic [127:0] k, b, gk, gb; int lat; logic fa; int bad = 0;
        k = STD_KEY; b = STD_PT;
        for (int i = 0; i < 32; i++) begin
            run_op(k, 64'(i), b, 1'b0, gk, gb, lat, fa);
            if (lat !== 4 || fa !== 1'b0) bad++;
            k = gk; b = gb;
        end
        n_total++; if (bad !== 0) $display("FAIL chain_timing: got %0d bad rounds expected 0", bad); else n_pass++;
        n_total++; if (b !== STD_CT) $display("FAIL chain_ciphertext: got %h expected %h", b, STD_CT); else n_pass++;
    endtask

`ifdef SPECK_DECRYPT_EN
    task automatic test_decrypt();
        logic [127:0] gk, gb; int lat; logic fa;
        run_op(STD_KEY, 64'd0, STD_BO, 1'b1, gk, gb, lat, fa);
        n_total++; if (gb !== STD_PT) $display("FAIL decrypt_block: got %h expected %h", gb, STD_PT); else n_pass++;
        n_total++; if (gk !== STD_KO) $display("FAIL decrypt_key: got %h expected %h", gk, STD_KO); else n_pass++;
        n_total++; if (lat !== 4) $display("FAIL decrypt_latency: got %0d expected 4", lat); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_standard_vector();
        test_reset_mid_op();
        test_zero();
        test_busy_ignore();
        test_held_start();
        test_random();
        test_chain();
`ifdef SPECK_DECRYPT_EN
        test_decrypt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
